// File: rtl/i2c_ctrl_pkg.sv
// Shared encodings for the I2C controller: engine command ops, scheduler states,
// and the command bundle presented to the byte/bit engine.
package i2c_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_START = 2'b00,
      OP_WRITE = 2'b01,
      OP_STOP  = 2'b10
   } cmd_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_POP,
      S_LATCH,
      S_DATA,
      S_STOP,
      S_BACKOFF
   } state_e;

   typedef struct packed {
      cmd_op_e    op;
      logic [7:0] data;
   } cmd_t;

   localparam logic RW_WRITE = 1'b0;
   localparam int   TIMER_W  = 16;

endpackage

// File: rtl/i2c_fifo_txn_sched_timer.sv
// Loadable down-counter shared by the idle-gap and retry-backoff waits.
// done fires on the enabled cycle that consumes the last count.
module sched_timer
   import i2c_ctrl_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - W'(1);
   end

   assign done = en && (cnt == W'(1));

endmodule

// File: rtl/i2c_fifo_txn_sched.sv
// Frames FIFO bytes into I2C write transactions (START, addr+W, data, STOP),
// with address-NACK retry/backoff, burst limit and idle-gap close.
module i2c_fifo_txn_sched
   import i2c_ctrl_pkg::*;
#(
   parameter int         DATA_WIDTH = 8,
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         MAX_BURST  = 8,
   parameter int         GAP_CYCLES = 16,
   parameter int         MAX_RETRY  = 3,
   parameter int         BACKOFF    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [1:0]            cmd_op,
   output logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  rsp_valid,
   input  logic                  rsp_nack,
   output logic                  busy,
   output logic                  nack_err,
   input  logic                  clear_err,
   output logic [7:0]            txn_bytes
);

   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
   localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

   state_e               state, state_n;
   logic                 acc;
   logic [DATA_WIDTH-1:0] data_q;
   logic [7:0]           retry_cnt;
   logic                 retry_path;
   logic                 rsp_done, xfer, err_set;
   logic                 tmr_load, tmr_en, tmr_done;
   logic [TIMER_W-1:0]   tmr_val;
   cmd_t                 cmd;

   // acc marks the current state's command as accepted and awaiting its response
   assign cmd_valid = (state inside {S_START, S_ADDR, S_DATA, S_STOP}) && !acc;
   assign xfer      = cmd_valid && cmd_ready;
   assign rsp_done  = acc && rsp_valid;
   assign busy      = (state != S_IDLE);
   assign cmd_op    = cmd.op;
   assign cmd_data  = cmd.data;

   always_comb begin
      state_n    = state;
      cmd.op     = OP_START;
      cmd.data   = '0;
      fifo_rd_en = 1'b0;
      case (state)
         S_IDLE:    if (enable && !fifo_empty && !nack_err) state_n = S_START;
         S_START:   if (rsp_done) state_n = S_ADDR;
         S_ADDR: begin
            cmd.op   = OP_WRITE;
            cmd.data = {SLAVE_ADDR, RW_WRITE};
            if (rsp_done) state_n = rsp_nack ? S_STOP : S_POP;
         end
         S_POP: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_n    = S_LATCH;
            end else if (tmr_done) begin
               state_n = S_STOP;
            end
         end
         S_LATCH:   state_n = S_DATA;
         S_DATA: begin
            cmd.op   = OP_WRITE;
            cmd.data = data_q;
            if (rsp_done) begin
               if (rsp_nack || !enable || (txn_bytes + 8'd1 >= BURST_MAX)) state_n = S_STOP;
               else                                                        state_n = S_POP;
            end
         end
         S_STOP: begin
            cmd.op = OP_STOP;
            if (rsp_done) state_n = retry_path ? S_BACKOFF : S_IDLE;
         end
         S_BACKOFF: if (tmr_done) state_n = S_START;
         default:   state_n = S_IDLE;
      endcase
   end

   // The timer preloads in every non-waiting state with the value the next wait needs
   assign tmr_load = !(state == S_POP || state == S_BACKOFF);
   assign tmr_en   = (state == S_POP && fifo_empty) || (state == S_BACKOFF);
   assign tmr_val  = (state_n == S_BACKOFF) ? TIMER_W'(BACKOFF) : TIMER_W'(GAP_CYCLES);

   sched_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .done     (tmr_done)
   );

   assign err_set = rsp_done && rsp_nack &&
                    (state == S_DATA || (state == S_ADDR && retry_cnt >= RETRY_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         acc        <= 1'b0;
         data_q     <= '0;
         txn_bytes  <= '0;
         retry_cnt  <= '0;
         retry_path <= 1'b0;
         nack_err   <= 1'b0;
      end else begin
         state <= state_n;
         if (state_n != state) acc <= 1'b0;
         else if (xfer)        acc <= 1'b1;
         if (state == S_LATCH) data_q <= fifo_data_out;
         if (state == S_IDLE && state_n == S_START)
            txn_bytes <= '0;
         else if (state == S_DATA && rsp_done && !rsp_nack && txn_bytes < BURST_MAX)
            txn_bytes <= txn_bytes + 8'd1;
         if (state == S_ADDR && rsp_done) begin
            if (!rsp_nack) begin
               retry_cnt <= '0;
            end else if (retry_cnt < RETRY_MAX) begin
               retry_cnt  <= retry_cnt + 8'd1;
               retry_path <= 1'b1;
            end else begin
               retry_cnt <= '0;
            end
         end
         if (state == S_STOP && rsp_done) retry_path <= 1'b0;
         // a new error outranks a simultaneous clear
         if (err_set)        nack_err <= 1'b1;
         else if (clear_err) nack_err <= 1'b0;
      end
   end

endmodule
